// File: rtl/slave_if_wr.sv
// slave_if_wr: round-robin arbiter granting one of four write masters onto a single slave write port.
// Optional: define SLV_WR_TIMEOUT_EN to force-release a grant whose master sits idle for TO_CYC cycles.
module slave_if_wr #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int SW     = 4,
  parameter int TO_CYC = 255
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iMst0WrReq,
  input  logic          iMst0WrValid,
  input  logic [AW-1:0] iMst0WrAddr,
  input  logic [SW-1:0] iMst0WrSel,
  input  logic [DW-1:0] iMst0WrData,
  input  logic          iMst0WrLast,
  output logic          oMst0WrReady,
  input  logic          iMst1WrReq,
  input  logic          iMst1WrValid,
  input  logic [AW-1:0] iMst1WrAddr,
  input  logic [SW-1:0] iMst1WrSel,
  input  logic [DW-1:0] iMst1WrData,
  input  logic          iMst1WrLast,
  output logic          oMst1WrReady,
  input  logic          iMst2WrReq,
  input  logic          iMst2WrValid,
  input  logic [AW-1:0] iMst2WrAddr,
  input  logic [SW-1:0] iMst2WrSel,
  input  logic [DW-1:0] iMst2WrData,
  input  logic          iMst2WrLast,
  output logic          oMst2WrReady,
  input  logic          iMst3WrReq,
  input  logic          iMst3WrValid,
  input  logic [AW-1:0] iMst3WrAddr,
  input  logic [SW-1:0] iMst3WrSel,
  input  logic [DW-1:0] iMst3WrData,
  input  logic          iMst3WrLast,
  output logic          oMst3WrReady,
  output logic          oSlvWrValid,
  output logic [AW-1:0] oSlvWrAddr,
  output logic [SW-1:0] oSlvWrSel,
  output logic [DW-1:0] oSlvWrData,
  output logic          oSlvWrLast,
  input  logic          iSlvWrReady,
  output logic [1:0]    oGrant,
  output logic          oBusy,
  output logic          oTimeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        stateReg, stateNext;
  logic [1:0]    grantReg, grantNext;
  logic [1:0]    rrPtrReg, rrPtrNext;

  logic [3:0]    mstReq, mstValid, mstLast, mstReady;
  logic [AW-1:0] mstAddr [4];
  logic [SW-1:0] mstSel  [4];
  logic [DW-1:0] mstData [4];

  logic          busy, grantValid, grantLast, xfer, normRelease, toHit;
  logic [1:0]    pickIdx, cand;
  logic          found;

  assign mstReq   = {iMst3WrReq,   iMst2WrReq,   iMst1WrReq,   iMst0WrReq};
  assign mstValid = {iMst3WrValid, iMst2WrValid, iMst1WrValid, iMst0WrValid};
  assign mstLast  = {iMst3WrLast,  iMst2WrLast,  iMst1WrLast,  iMst0WrLast};

  assign mstAddr[0] = iMst0WrAddr;
  assign mstAddr[1] = iMst1WrAddr;
  assign mstAddr[2] = iMst2WrAddr;
  assign mstAddr[3] = iMst3WrAddr;
  assign mstSel[0]  = iMst0WrSel;
  assign mstSel[1]  = iMst1WrSel;
  assign mstSel[2]  = iMst2WrSel;
  assign mstSel[3]  = iMst3WrSel;
  assign mstData[0] = iMst0WrData;
  assign mstData[1] = iMst1WrData;
  assign mstData[2] = iMst2WrData;
  assign mstData[3] = iMst3WrData;

  assign busy       = (stateReg == BUSY);
  assign grantValid = mstValid[grantReg];
  assign grantLast  = mstLast[grantReg];

  // Data path is a pure mux; only valid/last are qualified by the grant state.
  assign oSlvWrValid = busy & grantValid;
  assign oSlvWrLast  = busy & grantLast;
  assign oSlvWrAddr  = mstAddr[grantReg];
  assign oSlvWrSel   = mstSel[grantReg];
  assign oSlvWrData  = mstData[grantReg];

  assign xfer        = oSlvWrValid & iSlvWrReady;
  assign normRelease = (xfer & grantLast) | ~mstReq[grantReg];

  for (genvar gi = 0; gi < 4; gi++) begin : gReady
    assign mstReady[gi] = busy && (grantReg == 2'(gi)) && iSlvWrReady;
  end

  assign oMst0WrReady = mstReady[0];
  assign oMst1WrReady = mstReady[1];
  assign oMst2WrReady = mstReady[2];
  assign oMst3WrReady = mstReady[3];

  assign oGrant = grantReg;
  assign oBusy  = busy;

  // Search starts just after the last served master so every requester gets a turn.
  always_comb begin
    pickIdx = rrPtrReg;
    cand    = rrPtrReg;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = rrPtrReg + 2'(k);
      if (!found && mstReq[cand]) begin
        pickIdx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    grantNext = grantReg;
    rrPtrNext = rrPtrReg;
    unique case (stateReg)
      IDLE: begin
        if (|mstReq) begin
          stateNext = BUSY;
          grantNext = pickIdx;
        end
      end
      BUSY: begin
        if (normRelease || toHit) begin
          stateNext = IDLE;
          rrPtrNext = grantReg;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateReg <= IDLE;
      grantReg <= 2'd0;
      rrPtrReg <= 2'd3;
    end else begin
      stateReg <= stateNext;
      grantReg <= grantNext;
      rrPtrReg <= rrPtrNext;
    end
  end

`ifdef SLV_WR_TIMEOUT_EN
  logic [7:0] toCntReg, toCntNext;
  logic       timeoutReg;

  assign toHit    = busy && (toCntReg == 8'(TO_CYC));
  assign oTimeout = timeoutReg;

  // Counts consecutive granted cycles with no valid beat; a stalled valid beat holds it.
  always_comb begin
    toCntNext = 8'd0;
    if (busy && stateNext == BUSY) begin
      if (xfer)
        toCntNext = 8'd0;
      else if (!grantValid)
        toCntNext = toCntReg + 8'd1;
      else
        toCntNext = toCntReg;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      toCntReg   <= 8'd0;
      timeoutReg <= 1'b0;
    end else begin
      toCntReg   <= toCntNext;
      timeoutReg <= toHit && !normRelease;
    end
  end
`else
  assign toHit    = 1'b0;
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_slave_if_wr.sv
// tb_slave_if_wr: directed scenarios plus randomized traffic checked against a cycle-level arbitration model.
module tb_slave_if_wr;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int TB_TO = 4;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b1;
  logic [3:0]    req, vld, lst;
  logic [AW-1:0] addr [4];
  logic [SW-1:0] sel  [4];
  logic [DW-1:0] data [4];
  logic          slvRdy;
  logic          rdy0, rdy1, rdy2, rdy3;
  logic [3:0]    rdy;
  logic          sV, sL, busy, tmo;
  logic [AW-1:0] sA;
  logic [SW-1:0] sS;
  logic [DW-1:0] sD;
  logic [1:0]    grant;

  assign rdy = {rdy3, rdy2, rdy1, rdy0};

  always #5 iClk = ~iClk;

  slave_if_wr #(.AW(AW), .DW(DW), .SW(SW), .TO_CYC(TB_TO)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iMst0WrReq(req[0]), .iMst0WrValid(vld[0]), .iMst0WrAddr(addr[0]), .iMst0WrSel(sel[0]),
    .iMst0WrData(data[0]), .iMst0WrLast(lst[0]), .oMst0WrReady(rdy0),
    .iMst1WrReq(req[1]), .iMst1WrValid(vld[1]), .iMst1WrAddr(addr[1]), .iMst1WrSel(sel[1]),
    .iMst1WrData(data[1]), .iMst1WrLast(lst[1]), .oMst1WrReady(rdy1),
    .iMst2WrReq(req[2]), .iMst2WrValid(vld[2]), .iMst2WrAddr(addr[2]), .iMst2WrSel(sel[2]),
    .iMst2WrData(data[2]), .iMst2WrLast(lst[2]), .oMst2WrReady(rdy2),
    .iMst3WrReq(req[3]), .iMst3WrValid(vld[3]), .iMst3WrAddr(addr[3]), .iMst3WrSel(sel[3]),
    .iMst3WrData(data[3]), .iMst3WrLast(lst[3]), .oMst3WrReady(rdy3),
    .oSlvWrValid(sV), .oSlvWrAddr(sA), .oSlvWrSel(sS), .oSlvWrData(sD), .oSlvWrLast(sL),
    .iSlvWrReady(slvRdy), .oGrant(grant), .oBusy(busy), .oTimeout(tmo)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, who was served last, idle-beat count.
  bit mBusy, mTo;
  int mGrant, mLast, mCnt;
  int beats [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mReset();
    mBusy = 1'b0; mTo = 1'b0; mGrant = 0; mLast = 3; mCnt = 0;
  endtask

  task automatic clearIn();
    req = '0; vld = '0; lst = '0; slvRdy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      addr[n] = '0; sel[n] = '0; data[n] = '0;
    end
  endtask

  task automatic doReset();
    clearIn();
    iRst_n = 1'b0;
    mReset();
    repeat (2) @(posedge iClk);
    #3 iRst_n = 1'b1;
    @(posedge iClk);
    #1;
  endtask

  // Entered at posedge+1 with inputs set; checks mid-cycle, then advances the model across the edge.
  task automatic cycle();
    bit nBusy, nTo, xf;
    int nGrant, nLast, nCnt;
    logic [3:0] expRdy;
    #4;
    expRdy = (mBusy && slvRdy) ? 4'(1 << mGrant) : 4'd0;
    chk("busy", busy, mBusy);
    chk("grant", grant, mGrant);
    chk("ready", rdy, expRdy);
    chk("slvValid", sV, mBusy && vld[mGrant]);
    chk("slvLast", sL, mBusy && lst[mGrant]);
    chk("timeout", tmo, mTo);
    if (mBusy && vld[mGrant]) begin
      chk("slvAddr", sA, addr[mGrant]);
      chk("slvSel", sS, sel[mGrant]);
      chk("slvData", sD, data[mGrant]);
    end
    nBusy = mBusy; nGrant = mGrant; nLast = mLast; nCnt = 0; nTo = 1'b0;
    if (mBusy) begin
      xf = vld[mGrant] && slvRdy;
      if (xf) beats[mGrant]++;
      if ((xf && lst[mGrant]) || !req[mGrant]) begin
        nBusy = 1'b0;
        nLast = mGrant;
        $display("burst %s: master %0d, %0d beats", (xf && lst[mGrant]) ? "done" : "abort",
                 mGrant, beats[mGrant]);
      end
`ifdef SLV_WR_TIMEOUT_EN
      else if (mCnt == TB_TO) begin
        nBusy = 1'b0; nLast = mGrant; nTo = 1'b1;
        $display("burst timeout: master %0d, %0d beats", mGrant, beats[mGrant]);
      end
      else if (xf) nCnt = 0;
      else if (!vld[mGrant]) nCnt = mCnt + 1;
      else nCnt = mCnt;
`endif
    end else if (req != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        if (!nBusy && req[(mLast + k) % 4]) begin
          nBusy = 1'b1;
          nGrant = (mLast + k) % 4;
        end
      end
      beats[nGrant] = 0;
    end
    @(posedge iClk);
    mBusy = nBusy; mGrant = nGrant; mLast = nLast; mCnt = nCnt; mTo = nTo;
    #1;
  endtask

  int ord [5] = '{0, 1, 2, 3, 0};
  int xcnt;

  initial begin
    clearIn();
    mReset();
    #1 iRst_n = 1'b0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst grant", grant, 2'd0);
    chk("rst timeout", tmo, 1'b0);
    chk("rst ready", rdy, 4'd0);
    chk("rst slvValid", sV, 1'b0);
    doReset();

    // Single requester, 4-beat burst.
    req[2] = 1'b1;
    cycle();
    chk("t33 busy", busy, 1'b1);
    chk("t33 grant", grant, 2'd2);
    xcnt = 0;
    for (int b = 0; b < 4; b++) begin
      vld[2] = 1'b1; lst[2] = (b == 3); slvRdy = 1'b1;
      addr[2] = AW'($urandom); sel[2] = SW'($urandom); data[2] = $urandom;
      #1;
      if (sV && rdy[2]) xcnt++;
      cycle();
    end
    clearIn();
    chk("t33 xfers", xcnt, 4);
    chk("t33 idle", busy, 1'b0);
    cycle();

    // All masters requesting, single-beat bursts: round-robin order with an IDLE gap.
    doReset();
    req = 4'hF; vld = 4'hF; lst = 4'hF; slvRdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t34 gap", busy, 1'b0);
      cycle();
      chk("t34 busy", busy, 1'b1);
      chk("t34 order", grant, ord[i]);
      cycle();
    end
    clearIn();
    cycle();

    // Slave stalls: only the granted master's ready follows the slave.
    doReset();
    req[1] = 1'b1;
    cycle();
    vld[1] = 1'b1; data[1] = 32'hA5A5_1234; addr[1] = 12'h3C1; sel[1] = 4'h9;
    for (int i = 0; i < 4; i++) begin
      slvRdy = (i % 2 == 0);
      #1;
      chk("t35 ready", rdy, slvRdy ? 4'b0010 : 4'b0000);
      chk("t35 data", sD, 32'hA5A5_1234);
      cycle();
    end
    clearIn();
    cycle();
    chk("t35 release", busy, 1'b0);

    // Abort release then the pending master wins.
    doReset();
    req[3] = 1'b1;
    cycle();
    chk("t36 grant3", grant, 2'd3);
    vld[3] = 1'b1; slvRdy = 1'b1;
    cycle();
    cycle();
    req = 4'b0001; vld = '0;
    cycle();
    chk("t36 idle", busy, 1'b0);
    cycle();
    chk("t36 busy", busy, 1'b1);
    chk("t36 grant0", grant, 2'd0);
    clearIn();
    cycle();

    // Granted master never presents a beat.
    doReset();
    req[0] = 1'b1;
    cycle();
    repeat (5) cycle();
`ifdef SLV_WR_TIMEOUT_EN
    chk("t37 timeout", tmo, 1'b1);
    chk("t37 idle", busy, 1'b0);
`else
    chk("t37 timeout", tmo, 1'b0);
    chk("t37 busy", busy, 1'b1);
`endif
    clearIn();
    cycle();
    cycle();

    // Reset in the middle of a burst drops everything immediately.
    doReset();
    req[0] = 1'b1;
    cycle();
    vld[0] = 1'b1; slvRdy = 1'b1; data[0] = 32'h1111_0001;
    cycle();
    data[0] = 32'h1111_0002;
    #2 iRst_n = 1'b0;
    #1;
    chk("t38 busy", busy, 1'b0);
    chk("t38 grant", grant, 2'd0);
    chk("t38 ready", rdy, 4'd0);
    chk("t38 slvValid", sV, 1'b0);
    doReset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 7) == 0) req[n] = ~req[n];
        vld[n]  = ($urandom_range(0, 1) != 0);
        lst[n]  = ($urandom_range(0, 3) == 0);
        addr[n] = AW'($urandom);
        sel[n]  = SW'($urandom);
        data[n] = $urandom;
      end
      slvRdy = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/slave_if_wr.md
SLAVE_IF_WR -- requirements
Module: slave_if_wr

Interface
REQ-001 Parameter AW, default 12, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter SW, default 4, byte-select width.
REQ-004 Parameter TO_CYC, default 255, idle-beat timeout limit in cycles (8-bit counter range).
REQ-005 iClk  input  1  clock; all state updates on the rising edge.
REQ-006 iRst_n  input  1  reset, asynchronous, active-low.
REQ-007 iMst{n}WrReq  input  1  write request from master n, n=0..3.
REQ-008 iMst{n}WrValid  input  1  beat valid from master n.
REQ-009 iMst{n}WrAddr  input  AW  beat address from master n.
REQ-010 iMst{n}WrSel  input  SW  byte select from master n.
REQ-011 iMst{n}WrData  input  DW  write data from master n.
REQ-012 iMst{n}WrLast  input  1  last beat of the burst from master n.
REQ-013 oMst{n}WrReady  output  1  beat accepted, returned to master n.
REQ-014 oSlvWrValid, oSlvWrAddr, oSlvWrSel, oSlvWrData, oSlvWrLast  output  1/AW/SW/DW/1  forwarded beat to the slave port.
REQ-015 iSlvWrReady  input  1  slave accepts the current beat.
REQ-016 oGrant  output  2  index of the granted master.
REQ-017 oBusy  output  1  a grant is held (state BUSY).
REQ-018 oTimeout  output  1  one-cycle pulse when a grant is forcibly released.

Function
REQ-019 FSM states IDLE and BUSY; registers: state, oGrant, rr_ptr[1:0] (last served master).
REQ-020 IDLE: if any iMst{n}WrReq=1, grant the first requester in order rr_ptr+1, rr_ptr+2, ... (mod 4); next cycle state=BUSY, oGrant=that index.
REQ-021 IDLE: all oMst{n}WrReady=0; oSlvWrValid=0; oSlvWrLast=0.
REQ-022 BUSY: slave outputs combinationally mux granted master's Valid/Addr/Sel/Data/Last; oMst[oGrant]WrReady=iSlvWrReady; other readies 0.
REQ-023 Beat transfers when oSlvWrValid=1 and iSlvWrReady=1 in the same cycle.
REQ-024 BUSY, transfer with Last=1: next cycle state=IDLE, rr_ptr=oGrant.
REQ-025 BUSY, granted iMst[oGrant]WrReq=0 with no Last transfer: next cycle state=IDLE, rr_ptr=oGrant (abort release).
REQ-026 Requests from non-granted masters in BUSY are ignored until return to IDLE; minimum one IDLE cycle between grants.
REQ-027 Grant latency: one cycle from request sampled in IDLE to BUSY; zero-cycle combinational data/ready path in BUSY.
REQ-028 oBusy=1 exactly when state=BUSY; in IDLE the non-data slave outputs follow REQ-021; Addr/Sel/Data are don't-care.

Reset
REQ-029 iRst_n=0 forces state=IDLE, oGrant=0, rr_ptr=3 (master 0 first priority), timeout counter=0, oTimeout=0, independent of iClk.
REQ-030 Reset mid-burst drops the grant; no beat is forwarded while iRst_n=0; after release the burst restarts from arbitration.

Configuration
REQ-031 Macro SLV_WR_TIMEOUT_EN defined: an 8-bit counter increments each BUSY cycle with granted Valid=0 and clears on any transfer or in IDLE; when it equals TO_CYC, next cycle state=IDLE, rr_ptr=oGrant, oTimeout=1 for one cycle.
REQ-032 Macro SLV_WR_TIMEOUT_EN undefined: no counter logic; oTimeout tied 0; release only per REQ-024/REQ-025.

Verification
REQ-033 Reset release, iMst2WrReq=1 only -> next cycle oBusy=1, oGrant=2; 4-beat burst with iSlvWrReady=1 -> 4 transfers, IDLE the cycle after Last.
REQ-034 All four Req held high from reset, 1-beat bursts -> grant order 0,1,2,3,0, one IDLE cycle between each.
REQ-035 Master 1 granted, iSlvWrReady toggles 1,0,1,0 -> oMst1WrReady mirrors it, oMst0/2/3WrReady=0, beats unchanged while stalled.
REQ-036 Master 3 granted, iMst3WrReq drops after beat 2 without Last -> IDLE next cycle, pending master 0 granted next.
REQ-037 SLV_WR_TIMEOUT_EN, TO_CYC=4, master 0 granted, Valid held 0 -> oTimeout=1 on the 5th cycle after grant, state IDLE; undefined -> oBusy stays 1.
REQ-038 iRst_n asserted during beat 2 of a 4-beat burst -> oBusy=0, oGrant=0, all readies 0 immediately.
